// File: rtl/fft_out_serializer.sv
// fft_out_serializer
//   Captures one parallel FFT output frame into a local buffer and streams it
//   out one complex bin per cycle over a valid/ready handshake. The stream is
//   optionally bit-reverse reordered into natural frequency order. There is a
//   single frame buffer. A frame that arrives while a stream is still in flight
//   is dropped and reported on the overrun output.
//
//   Bins are packed {re, im}. Each half is a DATA_W-bit two's-complement value.
//   Bin j of fft_in sits at fft_in[j*2*DATA_W +: 2*DATA_W].
//
// Ports
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous, active-low reset
//   enable       1: block runs; 0: all state frozen, overrun forced low
//   fft_in       N parallel bins from the FFT core
//   in_valid     FFT core output valid; a rising edge marks a new frame
//   in_ready     1 when a frame event this cycle would be captured
//   data_out     current output bin (registered)
//   out_valid    data_out valid
//   out_ready    downstream accepts data_out this cycle
//   out_index    frequency index k of data_out
//   out_last     high together with k = N-1
//   overrun      1-cycle pulse: a frame was dropped because the block was busy
//   frame_count  number of completed frames; wraps from 0xFFFF to 0
module fft_out_serializer #(
    parameter int N           = 128,
    parameter int BIT_REVERSE = 1,
    parameter int DATA_W      = 16,
    parameter int IDX_W       = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N*2*DATA_W-1:0]   fft_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [2*DATA_W-1:0]     data_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_last,
    output logic                    overrun,
    output logic [15:0]             frame_count
);

    localparam int BIN_W = 2 * DATA_W;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     k_q, k_d;
    logic                 in_valid_q, in_valid_d;
    logic [BIN_W-1:0]     data_out_q, data_out_d;
    logic [15:0]          frame_count_q, frame_count_d;
    logic [BIN_W-1:0]     buf_q [N];
    logic [BIN_W-1:0]     buf_d [N];

    logic                 frame_evt;
    logic                 stream_beat;
    logic                 last_beat;
    logic                 capture;
    logic [IDX_W-1:0]     k_next;

    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] res;
        for (int b = 0; b < IDX_W; b++) begin
            res[b] = idx[IDX_W-1-b];
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] rd_addr(input logic [IDX_W-1:0] idx);
        return (BIT_REVERSE != 0) ? bitrev(idx) : idx;
    endfunction

    // A held-high in_valid yields exactly one capture.
    assign frame_evt   = in_valid & ~in_valid_q;
    assign stream_beat = (state_q == STREAM) & out_ready;
    assign last_beat   = stream_beat & out_last;
    assign in_ready    = (state_q == IDLE) | last_beat;
    assign capture     = enable & frame_evt & in_ready;
    assign overrun     = enable & frame_evt & ~in_ready;
    assign k_next      = k_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        in_valid_d    = in_valid_q;
        data_out_d    = data_out_q;
        frame_count_d = frame_count_q;
        buf_d         = buf_q;

        if (enable) begin
            in_valid_d = in_valid;

            if (stream_beat) begin
                k_d        = k_next;
                data_out_d = buf_q[rd_addr(k_next)];
                if (out_last) begin
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = IDLE;
                end
            end

            // Capture overrides the return to IDLE, so a frame arriving with the
            // accepted last bin streams back-to-back. Bin 0 is taken straight
            // from fft_in because the buffer only loads on this same edge.
            // bitrev(0) is 0, so both orderings start at bin 0.
            if (capture) begin
                state_d    = STREAM;
                k_d        = '0;
                data_out_d = fft_in[0 +: BIN_W];
                for (int j = 0; j < N; j++) begin
                    buf_d[j] = fft_in[j*BIN_W +: BIN_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            k_q           <= '0;
            in_valid_q    <= 1'b0;
            data_out_q    <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            in_valid_q    <= in_valid_d;
            data_out_q    <= data_out_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Buffer contents are don't-care after reset, so the buffer has no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign out_valid   = (state_q == STREAM);
    assign out_index   = k_q;
    assign out_last    = (state_q == STREAM) & (k_q == IDX_W'(N - 1));
    assign data_out    = data_out_q;
    assign frame_count = frame_count_q;

endmodule
